// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit, single-entry valid/ready output.
// Optional even-parity bit between data and stop when PARITY_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a valid bit equal to START_BIT
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the even-parity bit (PARITY_CHECK_EN only)
// STOP   | sampling the stop bit, then deliver, overrun or frame error
module serial_frame_deserializer #(
  parameter int   WIDTH     = 8,
  parameter logic START_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
`ifdef PARITY_CHECK_EN
    , S_PARITY = 2'd3
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  logic cnt_clr;
  logic shift_en;
  logic stop_hit;
  logic frame_good;
  logic hold_free;
  logic load;
  logic ovr_nxt;
  logic ferr_nxt;

`ifdef PARITY_CHECK_EN
  logic par_err;
  logic par_en;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state logic; nothing advances on cycles without a valid bit
  always_comb begin
    state_nxt = state;
    if (si_valid) begin
      case (state)
        S_IDLE: if (si == START_BIT) state_nxt = S_DATA;
        S_DATA: begin
          if (bit_cnt == LAST) begin
`ifdef PARITY_CHECK_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: state_nxt = S_STOP;
`endif
        S_STOP:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // output / datapath control
  always_comb begin
    cnt_clr   = si_valid && (state == S_IDLE) && (si == START_BIT);
    shift_en  = si_valid && (state == S_DATA);
    stop_hit  = si_valid && (state == S_STOP);
    hold_free = !dout_valid || dout_ready;
`ifdef PARITY_CHECK_EN
    par_en     = si_valid && (state == S_PARITY);
    frame_good = (si == ~START_BIT) && !par_err;
`else
    frame_good = (si == ~START_BIT);
`endif
    load     = stop_hit && frame_good && hold_free;
    ovr_nxt  = stop_hit && frame_good && !hold_free;
    ferr_nxt = stop_hit && !frame_good;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {si, shreg[WIDTH-1:1]};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

`ifdef PARITY_CHECK_EN
  // mismatch is held until the stop bit so a good stop cannot rescue the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         par_err <= 1'b0;
    else if (cnt_clr) par_err <= 1'b0;
    else if (par_en)  par_err <= si ^ (^shreg);
  end
`endif

  // a load in the same cycle as a drain keeps dout_valid high with the new word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (load) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      overrun   <= ovr_nxt;
      frame_err <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer (WIDTH=8, START_BIT=1); build with
// PARITY_CHECK_EN defined to exercise the parity frame format.
module tb_serial_frame_deserializer;

  localparam int   W  = 8;
  localparam logic SB = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         si = 1'b0;
  logic         si_valid = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         frame_err;

  serial_frame_deserializer #(.WIDTH(W), .START_BIT(SB)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int  exp_ovr  = 0;
  int  exp_ferr = 0;
  int  seen_ovr = 0;
  int  seen_ferr = 0;
  bit  m_full   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model tracks occupancy of the holding register
  // using the handshake rules and the expected outcome of each frame.
  task automatic step(input logic v, input logic b, input logic r,
                      input bit is_stop, input bit good, input logic [W-1:0] w);
    bit free, drain;
    si = b; si_valid = v; dout_ready = r;
    free  = !m_full || r;
    drain = m_full && r;
    if (v && is_stop && good && free) begin
      exp_q.push_back(w);
      m_full = 1;
    end else begin
      if (drain) m_full = 0;
      if (v && is_stop) begin
        if (good) exp_ovr++;
        else      exp_ferr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_r(input int rmode);
    if (rmode == 2) return logic'($urandom_range(0, 1));
    return logic'(rmode);
  endfunction

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 0, 0, '0);
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random; stop_r >= 0 overrides ready on the stop bit
  task automatic send_frame(input logic [W-1:0] w, input bit bad_stop, input bit bad_par,
                            input int gap_pct, input int rmode, input int stop_r);
    logic bits[$];
    bit   good;
    logic r;
    good = !bad_stop;
    bits.push_back(SB);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef PARITY_CHECK_EN
    bits.push_back((^w) ^ logic'(bad_par));
    if (bad_par) good = 0;
`endif
    bits.push_back(bad_stop ? SB : ~SB);
    for (int i = 0; i < bits.size(); i++) begin
      if ($urandom_range(1, 100) <= gap_pct)
        step(1'b0, logic'($urandom_range(0, 1)), pick_r(rmode), 0, 0, '0);
      r = pick_r(rmode);
      if (i == bits.size() - 1 && stop_r >= 0) r = logic'(stop_r);
      step(1'b1, bits[i], r, i == bits.size() - 1, good, w);
    end
  endtask

  // monitor: every accepted word must be the next one the model expects
  always @(negedge clk) begin
    if (rst) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL accept_unexpected: got 0x%0h expected none", dout);
        end else begin
          chk("accept_word", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end
      end
      if (overrun)   seen_ovr++;
      if (frame_err) seen_ferr++;
      if (overrun && frame_err) chk("ovr_ferr_exclusive", 32'd1, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_valid", {31'd0, dout_valid}, 32'd0);
    chk("reset_pulses", {30'd0, overrun, frame_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2, 1'b1);

    // single good frame, one-cycle valid
    send_frame(8'hA5, 0, 0, 0, 1, -1);
    chk("a5_valid", {31'd0, dout_valid}, 32'd1);
    chk("a5_dout", {24'd0, dout}, 32'hA5);
    chk("a5_pulses", {30'd0, overrun, frame_err}, 32'd0);
    idle(1, 1'b1);
    chk("a5_valid_drop", {31'd0, dout_valid}, 32'd0);

    // gapped input
    send_frame(8'hA5, 0, 0, 100, 1, -1);
    chk("gap_dout", {24'd0, dout}, 32'hA5);
    chk("gap_valid", {31'd0, dout_valid}, 32'd1);
    idle(2, 1'b1);

    // overrun
    send_frame(8'h3C, 0, 0, 0, 0, -1);
    send_frame(8'hC3, 0, 0, 0, 0, -1);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_dout_held", {24'd0, dout}, 32'h3C);
    idle(1, 1'b0);
    chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    idle(1, 1'b1);
    chk("ovr_drained", {31'd0, dout_valid}, 32'd0);

    // simultaneous drain and load
    send_frame(8'h3C, 0, 0, 0, 0, -1);
    send_frame(8'h81, 0, 0, 0, 0, 1);
    chk("dl_dout", {24'd0, dout}, 32'h81);
    chk("dl_valid", {31'd0, dout_valid}, 32'd1);
    chk("dl_no_ovr", {31'd0, overrun}, 32'd0);
    idle(2, 1'b1);

    // bad stop bit then good frame
    send_frame(8'hFF, 1, 0, 0, 1, -1);
    chk("bad_stop_ferr", {31'd0, frame_err}, 32'd1);
    chk("bad_stop_valid", {31'd0, dout_valid}, 32'd0);
    send_frame(8'h55, 0, 0, 0, 1, -1);
    chk("after_err_dout", {24'd0, dout}, 32'h55);
    chk("after_err_ferr", {31'd0, frame_err}, 32'd0);
    idle(2, 1'b1);

    // reset mid-frame with a word held
    send_frame(8'h3C, 0, 0, 0, 0, -1);
    step(1'b1, SB, 1'b0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, logic'(i % 2), 1'b0, 0, 0, '0);
    rst = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    exp_q.delete();
    m_full = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame(8'h0F, 0, 0, 0, 1, -1);
    chk("midrst_next_dout", {24'd0, dout}, 32'h0F);
    chk("midrst_next_valid", {31'd0, dout_valid}, 32'd1);
    idle(2, 1'b1);

`ifdef PARITY_CHECK_EN
    send_frame(8'hA5, 0, 0, 0, 1, -1);
    chk("par_ok_valid", {31'd0, dout_valid}, 32'd1);
    chk("par_ok_dout", {24'd0, dout}, 32'hA5);
    idle(2, 1'b1);
    send_frame(8'hA5, 0, 1, 0, 1, -1);
    chk("par_bad_ferr", {31'd0, frame_err}, 32'd1);
    chk("par_bad_valid", {31'd0, dout_valid}, 32'd0);
    idle(2, 1'b1);
`endif

    // randomized traffic
    for (int f = 0; f < 60; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--)
        step(1'b1, ~SB, pick_r(2), 0, 0, '0);
      send_frame(W'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 30, 2, -1);
    end
    idle(4, 1'b1);

    chk("words_left", exp_q.size(), 32'd0);
    chk("overrun_count", seen_ovr, exp_ovr);
    chk("frame_err_count", seen_ferr, exp_ferr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
